// File: rtl/ahb_lite_master_sm.sv
// AHB-Lite single-transfer initiator: turns a valid/ready command stream into
// pipelined NONSEQ/SINGLE transfers and returns one in-order response per command.
module ahb_lite_master_sm #(
   parameter int unsigned AW              = 32,
   parameter bit          CANCEL_ON_ERROR = 1'b1
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [1:0]    cmd_size,
   input  logic [31:0]   cmd_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
   output logic [AW-1:0] HADDR,
   output logic [1:0]    HTRANS,
   output logic          HWRITE,
   output logic [2:0]    HSIZE,
   output logic [2:0]    HBURST,
   output logic [31:0]   HWDATA,
   input  logic [31:0]   HRDATA,
   input  logic          HREADY,
   input  logic          HRESP
);

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_NONSEQ = 2'b10
   } htrans_e;

   // Address-phase slot; haddr/hwrite/hsize are the bus registers themselves.
   logic          a_valid_q, a_valid_d;
   logic [AW-1:0] haddr_q,   haddr_d;
   logic          hwrite_q,  hwrite_d;
   logic [2:0]    hsize_q,   hsize_d;
   logic [31:0]   a_wdata_q, a_wdata_d;

   // Data-phase slot
   logic          d_valid_q, d_valid_d;
   logic          d_write_q, d_write_d;
   logic [31:0]   hwdata_q,  hwdata_d;

   logic          cancel_q,    cancel_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q,   rsp_err_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;

   logic          accept;
   logic          advance;
   logic          promote;
   logic          complete;
   logic [AW-1:0] cmd_haddr;
   logic [2:0]    cmd_hsize;

   // Size 3 is treated as a word; low address bits are cleared to the transfer size.
   always_comb begin
      // NOTE: defaults first so every path assigns every variable and no latch is inferred.
      cmd_haddr = cmd_addr;
      cmd_hsize = 3'b010;
      case (cmd_size)
         2'd0: begin
            cmd_hsize = 3'b000;
         end
         2'd1: begin
            cmd_hsize    = 3'b001;
            cmd_haddr[0] = 1'b0;
         end
         default: begin
            cmd_hsize      = 3'b010;
            cmd_haddr[1:0] = 2'b00;
         end
      endcase
   end

   assign cmd_ready = !a_valid_q || (HREADY && !cancel_q);
   assign accept    = cmd_valid && cmd_ready;
   assign advance   = HREADY && !cancel_q;
   assign promote   = a_valid_q && advance;
   assign complete  = d_valid_q && HREADY;

   always_comb begin
      a_valid_d = accept || (a_valid_q && !advance);
      haddr_d   = haddr_q;
      hwrite_d  = hwrite_q;
      hsize_d   = hsize_q;
      a_wdata_d = a_wdata_q;
      if (accept) begin
         haddr_d   = cmd_haddr;
         hwrite_d  = cmd_write;
         hsize_d   = cmd_hsize;
         a_wdata_d = cmd_wdata;
      end

      d_valid_d = d_valid_q;
      d_write_d = d_write_q;
      hwdata_d  = hwdata_q;
      if (HREADY) begin
         d_valid_d = promote;
         if (promote) begin
            d_write_d = hwrite_q;
            if (hwrite_q) begin
               hwdata_d = a_wdata_q;
            end
         end
      end

      // Withdraw the pending address phase across the second ERROR cycle.
      cancel_d    = HREADY ? 1'b0 : (cancel_q || (CANCEL_ON_ERROR && a_valid_q && HRESP));

      rsp_valid_d = complete;
      rsp_err_d   = complete && HRESP;
      rsp_rdata_d = (complete && !d_write_q) ? HRDATA : 32'd0;
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid_q   <= 1'b0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b010;
         a_wdata_q   <= 32'd0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         hwdata_q    <= 32'd0;
         cancel_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         a_valid_q   <= a_valid_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         hwdata_q    <= hwdata_d;
         cancel_q    <= cancel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign HTRANS    = (a_valid_q && !cancel_q) ? TRANS_NONSEQ : TRANS_IDLE;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HBURST    = 3'b000;
   assign HWDATA    = hwdata_q;
   assign busy      = a_valid_q || d_valid_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_sm.sv
// Bench for ahb_lite_master_sm: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based transaction model.
module tb_ahb_lite_master_sm;

   localparam bit CANCEL = 1'b1;

   logic        HCLK;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   ahb_lite_master_sm #(.AW(32), .CANCEL_ON_ERROR(CANCEL)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t        mq[$];        // commands in flight, oldest first
   bit          m_in_data;    // mq[0] is in its data phase
   bit          m_withdrawn;  // address phase withdrawn for an ERROR
   bit          m_acc;        // command accepted at the most recent edge
   logic [31:0] m_haddr;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [31:0] m_hwdata;
   bit          m_rsp_valid;
   bit          m_rsp_err;
   logic [31:0] m_rsp_rdata;

   task automatic model_step();
      int   aidx;
      int   sz;
      bit   apres;
      bit   exp_ready;
      bit   complete;
      bit   adv;
      bit   acc;
      cmd_t adv_cmd;
      cmd_t nc;
      if (!HRESETn) begin
         mq.delete();
         m_in_data   = 1'b0;
         m_withdrawn = 1'b0;
         m_acc       = 1'b0;
         m_haddr     = 32'd0;
         m_hwrite    = 1'b0;
         m_hsize     = 3'd2;
         m_hwdata    = 32'd0;
         m_rsp_valid = 1'b0;
         m_rsp_err   = 1'b0;
         m_rsp_rdata = 32'd0;
      end
      aidx      = m_in_data ? 1 : 0;
      apres     = mq.size() > aidx;
      exp_ready = !apres || (HREADY && !m_withdrawn);

      check("cmp HTRANS",    32'(HTRANS),    (apres && !m_withdrawn) ? 32'h2 : 32'h0);
      check("cmp HADDR",     HADDR,          m_haddr);
      check("cmp HWRITE",    32'(HWRITE),    32'(m_hwrite));
      check("cmp HSIZE",     32'(HSIZE),     32'(m_hsize));
      check("cmp HBURST",    32'(HBURST),    32'h0);
      check("cmp HWDATA",    HWDATA,         m_hwdata);
      check("cmp cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      check("cmp busy",      32'(busy),      32'(mq.size() != 0));
      check("cmp rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid || !HRESETn) begin
         check("cmp rsp_err",   32'(rsp_err), 32'(m_rsp_err));
         check("cmp rsp_rdata", rsp_rdata,    m_rsp_rdata);
      end

      if (HRESETn) begin
         complete = m_in_data && HREADY;
         adv      = apres && HREADY && !m_withdrawn;
         acc      = cmd_valid && exp_ready;
         adv_cmd  = '0;
         if (apres) adv_cmd = mq[aidx];

         m_rsp_valid = complete;
         m_rsp_err   = complete && HRESP;
         m_rsp_rdata = 32'd0;
         if (complete) begin
            if (!mq[0].write) m_rsp_rdata = HRDATA;
            mq.delete(0);
         end
         if (adv && adv_cmd.write) m_hwdata = adv_cmd.wdata;
         if (HREADY) m_in_data = adv;
         m_withdrawn = HREADY ? 1'b0 : (m_withdrawn || (CANCEL && apres && HRESP));
         if (acc) begin
            sz       = (cmd_size == 2'd3) ? 2 : int'(cmd_size);
            nc.write = cmd_write;
            nc.addr  = cmd_addr - (cmd_addr % (32'd1 << sz));
            nc.wdata = cmd_wdata;
            mq.push_back(nc);
            m_haddr  = nc.addr;
            m_hwrite = cmd_write;
            m_hsize  = 3'(sz);
         end
         m_acc = acc;
      end
   endtask

   initial begin
      forever begin
         @(negedge HCLK);
         model_step();
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic sample();
      @(negedge HCLK);
   endtask

   task automatic drive_cmd(input logic v, input logic w, input logic [31:0] a,
                            input logic [1:0] s, input logic [31:0] d);
      cmd_valid = v;
      cmd_write = w;
      cmd_addr  = a;
      cmd_size  = s;
      cmd_wdata = d;
   endtask

   task automatic drive_slave(input logic rdy, input logic resp, input logic [31:0] rd);
      HREADY = rdy;
      HRESP  = resp;
      HRDATA = rd;
   endtask

   task automatic idle(input int n);
      drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
      drive_slave(1'b1, 1'b0, 32'd0);
      repeat (n) next_cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int  rsp_cnt;
      bit  err_pending;

      HRESETn = 1'b0;
      drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
      drive_slave(1'b1, 1'b0, 32'd0);
      repeat (3) @(posedge HCLK);
      sample();
      check("reset HTRANS",    32'(HTRANS),    32'h0);
      check("reset HADDR",     HADDR,          32'h0);
      check("reset HWRITE",    32'(HWRITE),    32'h0);
      check("reset HSIZE",     32'(HSIZE),     32'h2);
      check("reset HWDATA",    HWDATA,         32'h0);
      check("reset rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset busy",      32'(busy),      32'h0);
      check("reset cmd_ready", 32'(cmd_ready), 32'h1);
      next_cycle();
      HRESETn = 1'b1;
      idle(2);

      // Zero-wait write
      drive_cmd(1'b1, 1'b1, 32'h104, 2'd2, 32'hDEADBEEF);
      sample();
      check("wr c0 cmd_ready", 32'(cmd_ready), 32'h1);
      next_cycle(); drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0); sample();
      check("wr c1 HTRANS", 32'(HTRANS), 32'h2);
      check("wr c1 HWRITE", 32'(HWRITE), 32'h1);
      check("wr c1 HADDR",  HADDR,       32'h104);
      next_cycle(); sample();
      check("wr c2 HWDATA",    HWDATA,         32'hDEADBEEF);
      check("wr c2 HTRANS",    32'(HTRANS),    32'h0);
      check("wr c2 rsp_valid", 32'(rsp_valid), 32'h0);
      next_cycle(); sample();
      check("wr c3 rsp_valid", 32'(rsp_valid), 32'h1);
      check("wr c3 rsp_err",   32'(rsp_err),   32'h0);
      next_cycle(); sample();
      check("wr c4 rsp_valid", 32'(rsp_valid), 32'h0);
      check("wr c4 busy",      32'(busy),      32'h0);
      idle(2);

      // Read with two wait states
      drive_cmd(1'b1, 1'b0, 32'h20, 2'd2, 32'd0);
      next_cycle(); drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0); sample();
      check("rd c1 HTRANS", 32'(HTRANS), 32'h2);
      check("rd c1 HADDR",  HADDR,       32'h20);
      check("rd c1 HWRITE", 32'(HWRITE), 32'h0);
      next_cycle(); drive_slave(1'b0, 1'b0, 32'd0); sample();
      check("rd c2 busy", 32'(busy), 32'h1);
      next_cycle(); sample();
      check("rd c3 rsp_valid", 32'(rsp_valid), 32'h0);
      next_cycle(); drive_slave(1'b1, 1'b0, 32'h12345678); sample();
      check("rd c4 rsp_valid", 32'(rsp_valid), 32'h0);
      next_cycle(); drive_slave(1'b1, 1'b0, 32'd0); sample();
      check("rd c5 rsp_valid", 32'(rsp_valid), 32'h1);
      check("rd c5 rsp_rdata", rsp_rdata,      32'h12345678);
      next_cycle(); sample();
      check("rd c6 rsp_valid", 32'(rsp_valid), 32'h0);
      idle(2);

      // Back-to-back write/read/write
      drive_slave(1'b1, 1'b0, 32'hCAFEF00D);
      drive_cmd(1'b1, 1'b1, 32'h0, 2'd2, 32'h11111111);
      next_cycle(); drive_cmd(1'b1, 1'b0, 32'h4, 2'd2, 32'd0); sample();
      check("b2b c1 HTRANS",    32'(HTRANS),    32'h2);
      check("b2b c1 HADDR",     HADDR,          32'h0);
      check("b2b c1 cmd_ready", 32'(cmd_ready), 32'h1);
      next_cycle(); drive_cmd(1'b1, 1'b1, 32'h8, 2'd2, 32'h33333333); sample();
      check("b2b c2 HTRANS", 32'(HTRANS), 32'h2);
      check("b2b c2 HADDR",  HADDR,       32'h4);
      check("b2b c2 HWDATA", HWDATA,      32'h11111111);
      next_cycle(); drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0); sample();
      check("b2b c3 HTRANS",    32'(HTRANS),    32'h2);
      check("b2b c3 HADDR",     HADDR,          32'h8);
      check("b2b c3 rsp_valid", 32'(rsp_valid), 32'h1);
      check("b2b c3 rsp_rdata", rsp_rdata,      32'h0);
      next_cycle(); sample();
      check("b2b c4 rsp_valid", 32'(rsp_valid), 32'h1);
      check("b2b c4 rsp_rdata", rsp_rdata,      32'hCAFEF00D);
      check("b2b c4 HWDATA",    HWDATA,         32'h33333333);
      next_cycle(); sample();
      check("b2b c5 rsp_valid", 32'(rsp_valid), 32'h1);
      next_cycle(); sample();
      check("b2b c6 busy", 32'(busy), 32'h0);
      idle(2);

      // ERROR on read 0x40 while write 0x44 waits in address phase
      drive_cmd(1'b1, 1'b0, 32'h40, 2'd2, 32'd0);
      next_cycle(); drive_cmd(1'b1, 1'b1, 32'h44, 2'd2, 32'h44440044); sample();
      check("err c1 HADDR",     HADDR,          32'h40);
      check("err c1 cmd_ready", 32'(cmd_ready), 32'h1);
      next_cycle(); drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0); drive_slave(1'b0, 1'b1, 32'd0); sample();
      check("err c2 HTRANS", 32'(HTRANS), 32'h2);
      check("err c2 HADDR",  HADDR,       32'h44);
      next_cycle(); drive_slave(1'b1, 1'b1, 32'd0); sample();
      check("err c3 HTRANS",    32'(HTRANS),    32'h0);
      check("err c3 cmd_ready", 32'(cmd_ready), 32'h0);
      next_cycle(); drive_slave(1'b1, 1'b0, 32'd0); sample();
      check("err c4 rsp_valid", 32'(rsp_valid), 32'h1);
      check("err c4 rsp_err",   32'(rsp_err),   32'h1);
      check("err c4 HTRANS",    32'(HTRANS),    32'h2);
      check("err c4 HADDR",     HADDR,          32'h44);
      next_cycle(); sample();
      check("err c5 HWDATA",    HWDATA,         32'h44440044);
      check("err c5 HTRANS",    32'(HTRANS),    32'h0);
      check("err c5 rsp_valid", 32'(rsp_valid), 32'h0);
      next_cycle(); sample();
      check("err c6 rsp_valid", 32'(rsp_valid), 32'h1);
      check("err c6 rsp_err",   32'(rsp_err),   32'h0);
      idle(2);

      // Address masking per size (size 3 behaves as word)
      drive_cmd(1'b1, 1'b0, 32'h13, 2'd0, 32'd0);
      next_cycle(); drive_cmd(1'b1, 1'b0, 32'h13, 2'd1, 32'd0); sample();
      check("sz byte HADDR", HADDR,      32'h13);
      check("sz byte HSIZE", 32'(HSIZE), 32'h0);
      next_cycle(); drive_cmd(1'b1, 1'b0, 32'h13, 2'd2, 32'd0); sample();
      check("sz half HADDR", HADDR,      32'h12);
      check("sz half HSIZE", 32'(HSIZE), 32'h1);
      next_cycle(); drive_cmd(1'b1, 1'b0, 32'h17, 2'd3, 32'd0); sample();
      check("sz word HADDR", HADDR,      32'h10);
      check("sz word HSIZE", 32'(HSIZE), 32'h2);
      next_cycle(); drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0); sample();
      check("sz size3 HADDR", HADDR,      32'h14);
      check("sz size3 HSIZE", 32'(HSIZE), 32'h2);
      idle(3);

      // Reset during a stalled read data phase
      drive_cmd(1'b1, 1'b0, 32'h80, 2'd2, 32'd0);
      next_cycle(); drive_cmd(1'b0, 1'b0, 32'd0, 2'd0, 32'd0); sample();
      check("rst c1 HTRANS", 32'(HTRANS), 32'h2);
      next_cycle(); drive_slave(1'b0, 1'b0, 32'd0);
      #2 HRESETn = 1'b0;
      #1;
      check("rst HTRANS",    32'(HTRANS),    32'h0);
      check("rst busy",      32'(busy),      32'h0);
      check("rst cmd_ready", 32'(cmd_ready), 32'h1);
      check("rst HADDR",     HADDR,          32'h0);
      repeat (2) next_cycle();
      HRESETn = 1'b1;
      drive_slave(1'b1, 1'b0, 32'hBADBAD00);
      rsp_cnt = 0;
      repeat (4) begin
         sample();
         if (rsp_valid) rsp_cnt++;
      end
      check("rst no rsp after release", 32'(rsp_cnt), 32'h0);
      check("rst busy after release",   32'(busy),     32'h0);

      // Randomized traffic, checked every cycle by the model
      err_pending = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         next_cycle();
         if (!cmd_valid || m_acc) begin
            cmd_valid = ($urandom_range(0, 99) < 65);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_size  = 2'($urandom_range(0, 3));
            cmd_wdata = $urandom;
         end
         HRDATA = $urandom;
         if (err_pending) begin
            HREADY      = 1'b1;
            HRESP       = 1'b1;
            err_pending = 1'b0;
         end else if (m_in_data && $urandom_range(0, 99) < 12) begin
            HREADY      = 1'b0;
            HRESP       = 1'b1;
            err_pending = 1'b1;
         end else begin
            HRESP  = 1'b0;
            HREADY = ($urandom_range(0, 99) < 70);
         end
      end
      idle(5);
      sample();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master_sm.md
Name: ahb_lite_master_sm

Overview:
- Simple AHB-Lite initiator that turns a local valid/ready command stream into AHB single transfers: NONSEQ, HBURST=SINGLE.
- Drives SRAM-bridge slaves and peripheral slaves from a sequencer or test engine.
- Supports pipelined issue: the address phase of command N+1 overlaps the data phase of command N.
- Returns one response per command, in order.

Parameters:
- AW, 32, HADDR / cmd_addr width.
- CANCEL_ON_ERROR, 1, when 1 a pending address phase is withdrawn (HTRANS=IDLE) during the second ERROR cycle and then re-issued.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at HCLK rise
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AW  byte address
- cmd_size  in  2  0=byte, 1=half, 2=word (3 treated as 2)
- cmd_wdata  in  32  lane-aligned write data
- rsp_valid  out  1  one-cycle pulse, one per command
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  HRESP was ERROR
- busy  out  1  any command in address or data phase
- HADDR  out  AW
- HTRANS  out  2  IDLE=00, NONSEQ=10 only
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3  constant 000
- HWDATA  out  32
- HRDATA  in  32
- HREADY  in  1
- HRESP  in  1

Behaviour:
- Interface fixed: reset HRESETn, asynchronous, active-low; clock HCLK.

Reset values:
- HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0.
- rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
- Both phase slots empty, cancel flag clear.

Pipeline slots:
- Two slots: A (address phase: addr, write, size, wdata) and D (data phase: write, wdata).

Acceptance:
- cmd_ready = !A_valid | (HREADY & !cancel), combinational.
- An accepted command loads A at the clock edge; HADDR/HWRITE/HSIZE are registered from A.
- HTRANS = NONSEQ when A_valid & !cancel, else IDLE.
- First NONSEQ appears the cycle after acceptance.

Address alignment:
- HADDR low bits are forced per size: half clears bit0, word clears bits[1:0].
- HSIZE = {1'b0, cmd_size}, with size 3 mapped to 010.

Phase advance:
- At an edge with HREADY=1: D <= A (if A_valid & !cancel), else D empties; A <= new command or empties.
- At an edge with HREADY=0: A and D hold; all address-phase outputs stay stable.

Data phase:
- HWDATA driven from D.wdata throughout the data phase.
- HWDATA holds its last value when no write is in the data phase.

Response:
- At the edge where D_valid & HREADY=1, the next cycle has rsp_valid=1.
- rsp_err=HRESP; rsp_rdata=HRDATA for reads, 0 for writes.
- No backpressure on the response; the consumer must take the pulse.

Error handling (two-cycle ERROR: HRESP=1 & HREADY=0, then HRESP=1 & HREADY=1):
- At the first ERROR edge, if CANCEL_ON_ERROR and A_valid, set cancel.
- While cancel is set: HTRANS=IDLE and cmd_ready=!A_valid.
- At the following HREADY=1 edge: the D response issues with err=1, A stays in A (not promoted), cancel clears.
- The next cycle re-issues A as NONSEQ.
- With CANCEL_ON_ERROR=0, A proceeds normally.

Other rules:
- busy = A_valid | D_valid.
- Ordering is strictly in-order; at most 2 commands in flight.
- Reset mid-transfer: all slots are dropped immediately and outputs return to reset values. No response is produced for dropped commands.

Test Plan:
- Zero-wait write: write 0x0000_0104, size 2, data 0xDEADBEEF, accepted cycle 0 -> NONSEQ/HWRITE=1/HADDR=0x104 in cycle 1, HWDATA=0xDEADBEEF in cycle 2, rsp_valid cycle 3 with err=0.
- Read with 2 wait states at 0x20 (slave HREADY=0,0,1, HRDATA=0x1234_5678) -> HADDR held 3 cycles is not required, data phase lasts 3 cycles; rsp_rdata=0x12345678 one pulse.
- Back-to-back: write 0x0, read 0x4, write 0x8 with cmd_valid continuous, zero-wait -> NONSEQ on 3 consecutive cycles, 3 rsp pulses on consecutive cycles, in order.
- Error cancel: read 0x40 gets ERROR while write 0x44 is in address phase -> HTRANS=IDLE in the second error cycle, rsp_err=1 for 0x40, 0x44 re-issued NONSEQ the next cycle and completes err=0.
- Size masking: byte at 0x13 -> HADDR=0x13, HSIZE=0; half at 0x13 -> HADDR=0x12, HSIZE=1; word at 0x13 -> HADDR=0x10, HSIZE=2.
- Reset asserted during a read's data phase with HREADY=0 -> immediately HTRANS=IDLE, busy=0, cmd_ready=1; no rsp_valid after release.
